// File: rtl/lcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : lcd_pkg                                                      |
// | Description : Shared HD44780 command codes and the main sequencer state    |
// |               encoding used by the character-LCD text engine.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_2LINE = 8'h38;
  localparam logic [7:0] LCD_FUNC_1LINE = 8'h30;
  localparam logic [7:0] LCD_DISP_ON    = 8'h0C;
  localparam logic [7:0] LCD_CLEAR      = 8'h01;
  localparam logic [7:0] LCD_ENTRY      = 8'h06;
  localparam logic [7:0] LCD_DDRAM      = 8'h80;
  localparam logic [7:0] LCD_ROW2_OFS   = 8'h40;

  // WAIT_DONE and SETTLE are shared by every byte-sending state; the state
  // to resume after the settle wait is kept in a separate return register.
  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_IDLE      = 3'd1,
    ST_ROW_ADDR  = 3'd2,
    ST_CHAR      = 3'd3,
    ST_NEXT_ROW  = 3'd4,
    ST_WAIT_DONE = 3'd5,
    ST_SETTLE    = 3'd6
  } main_state_t;

endpackage
`default_nettype wire

// File: rtl/lcd_bus_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lcd_bus_writer                                               |
// | Description : Single-byte LCD bus transfer with setup / enable / hold      |
// |               timing and a start/done handshake.                           |
// | Revision    : 1.0 - initial release                                        |
// | Ports       : clk, rst_n     clock, async active-low reset                 |
// |               start          one-cycle request, accepted only when idle    |
// |               data, rs       byte and register select to transfer          |
// |               lcd_data/rs/en LCD pins (data/rs held until next transfer)   |
// |               done           one-cycle pulse after the hold phase          |
// +----------------------------------------------------------------------------+
module lcd_bus_writer #(
  parameter int SETUP_CYCLES = 4,
  parameter int EN_CYCLES    = 16,
  parameter int HOLD_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       rs,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic       done
);

  localparam int MAX_A = (SETUP_CYCLES > EN_CYCLES) ? SETUP_CYCLES : EN_CYCLES;
  localparam int MAX_C = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);

  typedef enum logic [1:0] {
    BW_IDLE  = 2'd0,
    BW_SETUP = 2'd1,
    BW_EN    = 2'd2,
    BW_HOLD  = 2'd3
  } bw_state_t;

  bw_state_t        state;
  logic [CNT_W-1:0] cnt;

  // Each phase loads its length minus one and leaves when the count hits zero,
  // so a phase lasts exactly its configured number of cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BW_IDLE;
      cnt      <= '0;
      lcd_data <= 8'h00;
      lcd_rs   <= 1'b0;
      lcd_en   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        BW_IDLE: begin
          if (start) begin
            lcd_data <= data;
            lcd_rs   <= rs;
            cnt      <= CNT_W'(SETUP_CYCLES - 1);
            state    <= BW_SETUP;
          end
        end
        BW_SETUP: begin
          if (cnt == '0) begin
            lcd_en <= 1'b1;
            cnt    <= CNT_W'(EN_CYCLES - 1);
            state  <= BW_EN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        BW_EN: begin
          if (cnt == '0) begin
            lcd_en <= 1'b0;
            cnt    <= CNT_W'(HOLD_CYCLES - 1);
            state  <= BW_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        BW_HOLD: begin
          if (cnt == '0) begin
            done  <= 1'b1;
            state <= BW_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= BW_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_text_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lcd_text_engine                                              |
// | Description : HD44780-class text driver: power-up init, then repaints the  |
// |               panel from a host-writable ROWS x COLS character buffer.     |
// | Revision    : 1.0 - initial release                                        |
// | Ports       : iCLK, iRST_N        clock, async active-low reset            |
// |               iWR/iADDR/iDATA     one-cycle buffer write (row*COLS+col)    |
// |               oINIT_DONE          init sequence finished (sticky)          |
// |               oBUSY               refresh pass in progress                 |
// |               LCD_DATA/RW/EN/RS   LCD pins (RW tied low)                   |
// +----------------------------------------------------------------------------+
module lcd_text_engine
  import lcd_pkg::*;
#(
  parameter int ROWS           = 2,
  parameter int COLS           = 16,
  parameter int ADDR_W         = 5,
  parameter int SETUP_CYCLES   = 4,
  parameter int EN_CYCLES      = 16,
  parameter int HOLD_CYCLES    = 4,
  parameter int DLY_CYCLES     = 262142,
  parameter int CLR_DLY_CYCLES = 262142,
  parameter int AUTO_REFRESH   = 0
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iWR,
  input  logic [ADDR_W-1:0] iADDR,
  input  logic [7:0]        iDATA,
  output logic              oINIT_DONE,
  output logic              oBUSY,
  output logic [7:0]        LCD_DATA,
  output logic              LCD_RW,
  output logic              LCD_EN,
  output logic              LCD_RS
);

  localparam int         CELLS    = ROWS * COLS;
  localparam int         DEPTH    = 1 << ADDR_W;
  localparam int         COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int         DLY_MAX  = (DLY_CYCLES > CLR_DLY_CYCLES) ? DLY_CYCLES : CLR_DLY_CYCLES;
  localparam int         DLY_W    = $clog2(DLY_MAX + 1);
  localparam logic [7:0] FUNC_SET = (ROWS == 2) ? LCD_FUNC_2LINE : LCD_FUNC_1LINE;
  localparam logic       LAST_ROW = (ROWS == 2);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  // Full power-of-two depth keeps the address a plain index; cells at or
  // beyond CELLS are never written and never displayed.
  logic [7:0]        buffer [DEPTH];
  main_state_t       state;
  main_state_t       ret_state;
  logic [1:0]        byte_idx;
  logic              row;
  logic [COL_W-1:0]  col;
  logic [DLY_W-1:0]  dly_cnt;
  logic              is_clr;
  logic              start;
  logic [7:0]        tx_data;
  logic              tx_rs;
  logic              dirty;
  logic              done;
  logic              wr_ok;
  logic              pass_start;
  logic [ADDR_W-1:0] cell_idx;
  logic [7:0]        init_byte;

  assign LCD_RW     = 1'b0;
  assign wr_ok      = iWR && (32'(iADDR) < 32'(CELLS));
  assign pass_start = (state == ST_IDLE) && (dirty || (AUTO_REFRESH != 0));
  assign cell_idx   = (row ? ADDR_W'(COLS) : '0) + ADDR_W'(col);

  always_comb begin
    init_byte = LCD_ENTRY;
    case (byte_idx)
      2'd0:    init_byte = FUNC_SET;
      2'd1:    init_byte = LCD_DISP_ON;
      2'd2:    init_byte = LCD_CLEAR;
      default: init_byte = LCD_ENTRY;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < DEPTH; i++) buffer[i] <= 8'h20;
    end else if (wr_ok) begin
      buffer[iADDR] <= iDATA;
    end
  end

  // A host write in the pass-start cycle must keep the flag set.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)         dirty <= 1'b1;
    else if (wr_ok)      dirty <= 1'b1;
    else if (pass_start) dirty <= 1'b0;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= ST_INIT;
      ret_state  <= ST_INIT;
      byte_idx   <= 2'd0;
      row        <= 1'b0;
      col        <= '0;
      dly_cnt    <= '0;
      is_clr     <= 1'b0;
      start      <= 1'b0;
      tx_data    <= 8'h00;
      tx_rs      <= 1'b0;
      oINIT_DONE <= 1'b0;
      oBUSY      <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        ST_INIT: begin
          start     <= 1'b1;
          tx_data   <= init_byte;
          tx_rs     <= 1'b0;
          is_clr    <= (init_byte == LCD_CLEAR);
          byte_idx  <= byte_idx + 1'b1;
          ret_state <= (byte_idx == 2'd3) ? ST_IDLE : ST_INIT;
          state     <= ST_WAIT_DONE;
        end
        ST_IDLE: begin
          if (pass_start) begin
            oBUSY <= 1'b1;
            row   <= 1'b0;
            state <= ST_ROW_ADDR;
          end
        end
        ST_ROW_ADDR: begin
          start     <= 1'b1;
          tx_data   <= row ? (LCD_DDRAM | LCD_ROW2_OFS) : LCD_DDRAM;
          tx_rs     <= 1'b0;
          is_clr    <= 1'b0;
          col       <= '0;
          ret_state <= ST_CHAR;
          state     <= ST_WAIT_DONE;
        end
        ST_CHAR: begin
          start   <= 1'b1;
          tx_data <= buffer[cell_idx];
          tx_rs   <= 1'b1;
          is_clr  <= 1'b0;
          if (col == LAST_COL) begin
            ret_state <= ST_NEXT_ROW;
          end else begin
            col       <= col + 1'b1;
            ret_state <= ST_CHAR;
          end
          state <= ST_WAIT_DONE;
        end
        ST_NEXT_ROW: begin
          if (row == LAST_ROW) begin
            oBUSY <= 1'b0;
            state <= ST_IDLE;
          end else begin
            row   <= 1'b1;
            state <= ST_ROW_ADDR;
          end
        end
        ST_WAIT_DONE: begin
          if (done) begin
            dly_cnt <= is_clr ? DLY_W'(CLR_DLY_CYCLES - 1) : DLY_W'(DLY_CYCLES - 1);
            state   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (dly_cnt == '0) begin
            // Only the last init byte resumes into IDLE.
            if (ret_state == ST_IDLE) oINIT_DONE <= 1'b1;
            state <= ret_state;
          end else begin
            dly_cnt <= dly_cnt - 1'b1;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  lcd_bus_writer #(
    .SETUP_CYCLES (SETUP_CYCLES),
    .EN_CYCLES    (EN_CYCLES),
    .HOLD_CYCLES  (HOLD_CYCLES)
  ) u_bus_writer (
    .clk      (iCLK),
    .rst_n    (iRST_N),
    .start    (start),
    .data     (tx_data),
    .rs       (tx_rs),
    .lcd_data (LCD_DATA),
    .lcd_rs   (LCD_RS),
    .lcd_en   (LCD_EN),
    .done     (done)
  );

endmodule
`default_nettype wire
